// File: rtl/div_seq.sv
// Sequential radix-2 restoring divider for DIV/DIVU in the EX stage.
// Produces {remainder, quotient} and holds the pipeline while it iterates.
module div_seq #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  signed_i,
  input  logic                  annul_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stallreq_o
);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]     quot_q, quot_d;
  logic [DATA_W-1:0]     rem_q, rem_d;
  logic [DATA_W-1:0]     dvsr_q, dvsr_d;
  logic                  neg_dvd_q, neg_dvd_d;
  logic                  neg_dvs_q, neg_dvs_d;
  logic                  sgn_q, sgn_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  ready_q, ready_d;

  logic [DATA_W:0]       rem_shift_s;
  logic [DATA_W:0]       trial_s;
  logic                  q_bit_s;
  logic [DATA_W-1:0]     rem_next_s;
  logic [DATA_W-1:0]     quot_next_s;
  logic [DATA_W-1:0]     quot_fix_s;
  logic [DATA_W-1:0]     rem_fix_s;
  logic [DATA_W-1:0]     op1_abs_s;
  logic [DATA_W-1:0]     op2_abs_s;
  logic                  stall_s;

  // Next-state, iteration datapath and stall request
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dvsr_d    = dvsr_q;
    neg_dvd_d = neg_dvd_q;
    neg_dvs_d = neg_dvs_q;
    sgn_d     = sgn_q;
    result_d  = result_q;
    ready_d   = ready_q;
    stall_s   = 1'b0;

    // Trial subtraction at DATA_W+1 bits; the top bit is the borrow/sign
    rem_shift_s = {rem_q, quot_q[DATA_W-1]};
    trial_s     = rem_shift_s - {1'b0, dvsr_q};
    if (!trial_s[DATA_W]) begin
      q_bit_s    = 1'b1;
      rem_next_s = trial_s[DATA_W-1:0];
    end else begin
      q_bit_s    = 1'b0;
      rem_next_s = rem_shift_s[DATA_W-1:0];
    end
    quot_next_s = {quot_q[DATA_W-2:0], q_bit_s};
    quot_fix_s  = (sgn_q && (neg_dvd_q ^ neg_dvs_q)) ? -quot_next_s : quot_next_s;
    rem_fix_s   = (sgn_q && neg_dvd_q) ? -rem_next_s : rem_next_s;
    op1_abs_s   = (signed_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    op2_abs_s   = (signed_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

    case (state_q)
      S_FREE: begin
        if (start_i && !annul_i) begin
          stall_s   = 1'b1;
          quot_d    = op1_abs_s;
          dvsr_d    = op2_abs_s;
          neg_dvd_d = signed_i & opdata1_i[DATA_W-1];
          neg_dvs_d = signed_i & opdata2_i[DATA_W-1];
          sgn_d     = signed_i;
          rem_d     = {DATA_W{1'b0}};
          cnt_d     = {CNT_W{1'b0}};
          if (opdata2_i == {DATA_W{1'b0}}) begin
            state_d = S_BYZERO;
          end else begin
            state_d = S_ON;
          end
        end else begin
          state_d = S_FREE;
        end
      end
      S_BYZERO: begin
        if (annul_i) begin
          state_d = S_FREE;
        end else begin
          stall_s  = 1'b1;
          state_d  = S_END;
          result_d = {(2*DATA_W){1'b0}};
          ready_d  = 1'b1;
        end
      end
      S_ON: begin
        if (annul_i) begin
          state_d = S_FREE;
        end else begin
          stall_s = 1'b1;
          cnt_d   = cnt_q + CNT_ONE;
          quot_d  = quot_next_s;
          rem_d   = rem_next_s;
          // The final iteration's result goes straight into result_o
          if (cnt_q == CNT_LAST) begin
            state_d  = S_END;
            result_d = {rem_fix_s, quot_fix_s};
            ready_d  = 1'b1;
          end else begin
            state_d = S_ON;
          end
        end
      end
      S_END: begin
        if (annul_i || !start_i) begin
          state_d = S_FREE;
          ready_d = 1'b0;
        end else begin
          state_d = S_END;
        end
      end
      default: begin
        state_d = S_FREE;
        ready_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_FREE;
      cnt_q     <= {CNT_W{1'b0}};
      quot_q    <= {DATA_W{1'b0}};
      rem_q     <= {DATA_W{1'b0}};
      dvsr_q    <= {DATA_W{1'b0}};
      neg_dvd_q <= 1'b0;
      neg_dvs_q <= 1'b0;
      sgn_q     <= 1'b0;
      result_q  <= {(2*DATA_W){1'b0}};
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      dvsr_q    <= dvsr_d;
      neg_dvd_q <= neg_dvd_d;
      neg_dvs_q <= neg_dvs_d;
      sgn_q     <= sgn_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign stallreq_o = rst & stall_s;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: scoreboard of expected {remainder, quotient}
// results, latency/stall counting, annul, reset abort and END hold.
module tb_div_seq;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic        annul_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int passed;
  int total;
  logic [63:0] exp_q[$];
  logic [63:0] last_res;

  div_seq #(.DATA_W(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i),
    .annul_i(annul_i), .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .result_o(result_o), .ready_o(ready_o), .stallreq_o(stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive point: just after the rising edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_div(input logic [31:0] op1, input logic [31:0] op2, input logic sgn,
                         input logic [63:0] exp_res, input int exp_lat, input int hold_extra);
    int cyc;
    int stall_cnt;
    bit got;
    logic [63:0] expected;
    exp_q.push_back(exp_res);
    next_cycle();
    start_i = 1'b1; signed_i = sgn; opdata1_i = op1; opdata2_i = op2;
    cyc = 0; stall_cnt = 0; got = 1'b0;
    while (!got && cyc <= 60) begin
      @(negedge clk);
      if (ready_o) begin
        got = 1'b1;
      end else begin
        if (stallreq_o) stall_cnt++;
        next_cycle();
        cyc++;
        // Operands must be ignored after acceptance
        opdata1_i = $urandom();
        opdata2_i = $urandom();
        signed_i  = 1'($urandom_range(0, 1));
      end
    end
    chk("ready_latency", 64'(cyc), 64'(exp_lat));
    chk("stall_cycles", 64'(stall_cnt), 64'(exp_lat));
    if (exp_q.size() == 0) begin
      chk("scoreboard_nonempty", 64'(exp_q.size()), 64'(1));
      expected = exp_res;
    end else begin
      expected = exp_q.pop_front();
    end
    chk("result", result_o, expected);
    chk("stall_in_end", {63'd0, stallreq_o}, 64'd0);
    for (int k = 0; k < hold_extra; k++) begin
      next_cycle();
      @(negedge clk);
      chk("hold_ready", {63'd0, ready_o}, 64'd1);
      chk("hold_result", result_o, expected);
      chk("hold_stall", {63'd0, stallreq_o}, 64'd0);
    end
    next_cycle();
    start_i = 1'b0;
    @(negedge clk);
    chk("drop_ready_still", {63'd0, ready_o}, 64'd1);
    next_cycle();
    @(negedge clk);
    chk("free_ready", {63'd0, ready_o}, 64'd0);
    chk("free_result_held", result_o, expected);
    chk("free_stall", {63'd0, stallreq_o}, 64'd0);
    last_res = expected;
  endtask

  initial begin
    int stall_cnt;
    passed = 0; total = 0;
    rst = 1'b0; start_i = 1'b1; signed_i = 1'b0; annul_i = 1'b0;
    opdata1_i = 32'd100; opdata2_i = 32'd7;

    // Reset state, with a request held to show stall is forced low
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {63'd0, ready_o}, 64'd0);
    chk("rst_result", result_o, 64'd0);
    chk("rst_stall", {63'd0, stallreq_o}, 64'd0);
    start_i = 1'b0;
    next_cycle();
    rst = 1'b1;
    next_cycle();

    run_div(32'd100, 32'd7, 1'b0, {32'h0000_0002, 32'h0000_000E}, 33, 4);
    run_div(32'hFFFF_FFF9, 32'h0000_0002, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 0);
    run_div(32'h0000_0007, 32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD}, 33, 0);
    run_div(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, {32'hFFFF_FFFE, 32'h0000_000E}, 33, 0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0000_0000, 32'h8000_0000}, 33, 0);

    // Annul during iteration 10
    next_cycle();
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3;
    stall_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (stallreq_o) stall_cnt++;
      next_cycle();
    end
    chk("annul_pre_stall", 64'(stall_cnt), 64'd10);
    annul_i = 1'b1;
    @(negedge clk);
    chk("annul_stall_drop", {63'd0, stallreq_o}, 64'd0);
    chk("annul_ready", {63'd0, ready_o}, 64'd0);
    next_cycle();
    annul_i = 1'b0; start_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("annul_free_ready", {63'd0, ready_o}, 64'd0);
      chk("annul_free_stall", {63'd0, stallreq_o}, 64'd0);
      chk("annul_result_held", result_o, last_res);
      next_cycle();
    end
    run_div(32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33, 0);

    run_div(32'd5, 32'd0, 1'b0, 64'd0, 2, 1);
    run_div(32'd50, 32'd5, 1'b0, {32'd0, 32'd10}, 33, 0);

    // Reset during iteration 20
    next_cycle();
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'hFFFF_FFF0; opdata2_i = 32'd3;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      next_cycle();
    end
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_stall_forced", {63'd0, stallreq_o}, 64'd0);
    next_cycle();
    @(negedge clk);
    chk("rst_mid_result", result_o, 64'd0);
    chk("rst_mid_ready", {63'd0, ready_o}, 64'd0);
    chk("rst_mid_stall", {63'd0, stallreq_o}, 64'd0);
    start_i = 1'b0;
    rst = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("post_rst_ready", {63'd0, ready_o}, 64'd0);
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, {32'd0, 32'hFFFF_FFFF}, 33, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle divider sequencer for the EX stage of the 5-stage MIPS pipeline. It accepts one DIV/DIVU request at a time from EX and runs a radix-2 restoring division, one quotient bit per cycle. While busy it holds the pipeline through `stallreq_o`, which feeds the central stall controller that drives the `StallBus`. It returns `{remainder, quotient}` for the HI/LO write.

## Interface
- `DATA_W`, 32, operand width; the iteration count equals `DATA_W`.
- `CNT_W`, 6, iteration counter width; must satisfy 2^CNT_W > `DATA_W`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset; sampled on `clk` rising edge, reset when 0.
- `start_i`  in  1  division request from EX; held high until `ready_o` is seen.
- `signed_i`  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with `start_i`.
- `annul_i`  in  1  cancel the current or pending operation (exception/flush).
- `opdata1_i`  in  DATA_W  dividend; sampled at acceptance.
- `opdata2_i`  in  DATA_W  divisor; sampled at acceptance.
- `result_o`  out  2*DATA_W  `{remainder, quotient}`; `[63:32]` goes to HI, `[31:0]` to LO.
- `ready_o`  out  1  result valid.
- `stallreq_o`  out  1  request to stall IF..EX while the division is in progress.

## Operation
- FSM states: FREE, BYZERO, ON, END.
- **FREE**
  - If `start_i & !annul_i` and `opdata2_i == 0`, go to BYZERO.
  - If `start_i & !annul_i` otherwise, go to ON and clear the counter.
  - At acceptance, latch operands (as absolute values when `signed_i`), the dividend sign, the divisor sign and `signed_i`.
- **ON**, one iteration per cycle:
  - Form `{partial_rem, dividend} << 1`.
  - Compute `trial = partial_rem - divisor` at DATA_W+1 bits.
  - If `trial` is non-negative, the quotient bit is 1 and `partial_rem` takes `trial`; otherwise the bit is 0.
  - The counter increments each iteration.
  - On the edge that completes iteration `DATA_W`, go to END and register `result_o`.
  - If `annul_i` is high in ON, go to FREE and discard the partial result.
- **Sign fix-up** (signed only, applied when registering the result):
  - Quotient is negated if the dividend and divisor signs differ.
  - Remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0, with no trap.
- **BYZERO**: on the next edge go to END with `result_o = 0` (HI = 0, LO = 0).
- **END**
  - `ready_o = 1` and `result_o` is stable.
  - If `start_i == 0`, go to FREE and clear `ready_o`. Otherwise stay in END (the request is still held while EX is stalled by other sources).
  - `annul_i` in END goes to FREE.
- **`stallreq_o`** (combinational) is 1 when any of these hold:
  - state is ON;
  - state is BYZERO;
  - state is FREE with `start_i & !annul_i` (this stalls in the request cycle).
  
  It is 0 in END, which lets EX advance and write HI/LO.
- Annul has priority over start in every state.
- Operand changes after acceptance are ignored.

## Timing
- Reset (`rst == 0` at an edge):
  - state = FREE, counter = 0, `result_o` = 0, `ready_o` = 0, all latched operands = 0.
  - While `rst == 0`, `stallreq_o` is forced to 0.
- Reset mid-operation aborts immediately. No result is produced.
- Latency, with the request accepted at edge E0:
  - Normal division: ready at E0+`DATA_W`+1 (edge 33), so `ready_o` is high in the following cycle; `stallreq_o` is high for 33 consecutive cycles.
  - Divide by zero: ready at E0+2; `stallreq_o` is high for 2 cycles.
- Back-to-back operations: a new request is accepted no earlier than one cycle after END→FREE, because `start_i` must drop for at least one edge.
- Annul: effective at the edge where it is sampled. `stallreq_o` falls in the same cycle (combinational), and the state is FREE after that edge.
- `result_o` changes only on entry to END or on reset. It is held through FREE until the next END.

## Test plan
- Unsigned 100 / 7 (`signed_i=0`), `start_i` held → `ready_o` rises 33 cycles after acceptance; `result_o` = {0x00000002, 0x0000000E}; `stallreq_o` is high for exactly 33 cycles.
- Signed −7 / 2 (0xFFFFFFF9, 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- Divide by zero, 5 / 0 → `ready_o` 2 cycles after acceptance; `result_o` = 0; `stallreq_o` is high for 2 cycles.
- Annul during iteration 10 → FREE after the edge; `ready_o` never asserts; `stallreq_o` drops in the annul cycle. A new 9 / 3 request then yields {0, 3} with full latency.
- Reset (`rst=0`) asserted during iteration 20 → all outputs 0 next cycle. After release, a 0xFFFFFFFF / 1 unsigned request yields {0, 0xFFFFFFFF}.
- `start_i` held 4 extra cycles in END → `ready_o` and `result_o` are stable and `stallreq_o` = 0 throughout. FREE follows the first edge with `start_i` = 0.
